// File: rtl/tag_fl_pkg.sv
// Shared defaults and helpers for the rename-stage free-tag list.
// Optional feature macro: TAG_FL_BYPASS_EN (return-to-allocate bypass when empty).
package tag_fl_pkg;

   localparam int unsigned TAG_WIDTH_DEF = 6;
   localparam int unsigned NUM_RET_DEF   = 2;
   localparam int unsigned DEPTH         = 2 ** TAG_WIDTH_DEF;
   localparam int unsigned PTR_W         = TAG_WIDTH_DEF + 1;

   // Number of returns that fit; vld is the (up to) two-channel valid vector.
   // When only one slot is free the lower valid channel keeps it.
   function automatic logic [1:0] fl_accept_cnt(input logic [1:0] vld, input int unsigned free);
      logic [1:0] n;
      n = 2'(vld[0]) + 2'(vld[1]);
      if (free < 32'(n)) n = free[1:0];
      return n;
   endfunction

endpackage

// File: rtl/tag_fl_storage.sv
// Tag storage for the free list: two write ports, one asynchronous read port,
// synchronous reinitialisation to identity contents (entry i holds tag i).
module tag_fl_storage
   import tag_fl_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 i_init,
   input  logic                 i_we0,
   input  logic [TAG_WIDTH-1:0] i_waddr0,
   input  logic [TAG_WIDTH-1:0] i_wdata0,
   input  logic                 i_we1,
   input  logic [TAG_WIDTH-1:0] i_waddr1,
   input  logic [TAG_WIDTH-1:0] i_wdata1,
   input  logic [TAG_WIDTH-1:0] i_raddr,
   output logic [TAG_WIDTH-1:0] o_rdata
);

   localparam int unsigned NUM_ENT = 2 ** TAG_WIDTH;

   logic [TAG_WIDTH-1:0] r_mem [NUM_ENT];

   // Identity fill on init, otherwise up to two writes (addresses never collide).
   always_ff @(posedge clk) begin
      if (i_init) begin
         for (int unsigned i = 0; i < NUM_ENT; i++) begin
            r_mem[i] <= TAG_WIDTH'(i);
         end
      end else begin
         if (i_we0) r_mem[i_waddr0] <= i_wdata0;
         if (i_we1) r_mem[i_waddr1] <= i_wdata1;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tag_free_list.sv
// Free-tag list for rename: one allocation per cycle, up to NUM_RET returns per
// cycle, occupancy/full/empty flags, sticky error and single-level checkpoint of RP.
// Optional feature macro: TAG_FL_BYPASS_EN -- when empty, a channel-0 return is
// handed straight to an allocation in the same cycle.
module tag_free_list
   import tag_fl_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF,
   parameter int unsigned NUM_RET   = NUM_RET_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [NUM_RET*TAG_WIDTH-1:0] cdb_tag_tf,
   input  logic [NUM_RET-1:0]           cdb_tag_tf_valid,
   input  logic                         ren_tf,
   output logic [TAG_WIDTH-1:0]         tagout_tf,
   output logic                         ef_tf,
   output logic                         ff_tf,
   output logic [TAG_WIDTH:0]           count_tf,
   input  logic                         ckpt_take,
   input  logic                         ckpt_restore,
   output logic                         err_tf
);

   localparam int unsigned NUM_ENT = 2 ** TAG_WIDTH;
   localparam int unsigned PW      = TAG_WIDTH + 1;

   logic [PW-1:0]        r_rp;
   logic [PW-1:0]        r_wp;
   logic [PW-1:0]        r_ckpt;
   logic                 r_err;

   logic [1:0]           w_vld2;
   logic [TAG_WIDTH-1:0] w_tag0;
   logic [TAG_WIDTH-1:0] w_tag1;
   logic [1:0]           w_acc_vld;
   logic [1:0]           w_n;
   int unsigned          w_free;
   logic                 w_empty;
   logic [PW-1:0]        w_count;
   logic                 w_bypass;
   logic                 w_alloc;
   logic                 w_underflow;
   logic                 w_overflow;
   logic                 w_illegal;
   logic [PW-1:0]        w_wp_next;
   logic [PW-1:0]        w_rp_next;
   logic [PW-1:0]        w_ckpt_next;
   logic [PW-1:0]        w_ckpt_dist;
   logic                 w_init;
   logic                 w_we0;
   logic                 w_we1;
   logic [TAG_WIDTH-1:0] w_wd0;
   logic [TAG_WIDTH-1:0] w_rdata;

   // Normalise the return channels to a two-wide view (channel 1 absent when NUM_RET=1).
   always_comb begin
      w_vld2    = '0;
      w_tag0    = cdb_tag_tf[TAG_WIDTH-1:0];
      w_tag1    = '0;
      w_vld2[0] = cdb_tag_tf_valid[0];
      if (NUM_RET > 1) begin
         w_vld2[1] = cdb_tag_tf_valid[NUM_RET-1];
         w_tag1    = cdb_tag_tf[(NUM_RET-1)*TAG_WIDTH +: TAG_WIDTH];
      end
   end

   assign w_empty = (r_wp == r_rp);
   assign w_count = r_wp - r_rp;

`ifdef TAG_FL_BYPASS_EN
   assign w_bypass = w_empty & w_vld2[0] & ren_tf & ~ckpt_restore;
`else
   assign w_bypass = 1'b0;
`endif

   // Pointer arithmetic, acceptance limit and error detection.
   always_comb begin
      // A restore cycle never allocates, so the acceptance limit does not depend on it.
      w_alloc     = ren_tf & ~w_empty & ~ckpt_restore;
      w_underflow = ren_tf & w_empty & ~ckpt_restore & ~w_bypass;
      w_acc_vld   = {w_vld2[1], w_vld2[0] & ~w_bypass};
      w_free      = NUM_ENT - 32'(w_count) + 32'(w_alloc);
      w_n         = fl_accept_cnt(w_acc_vld, w_free);
      w_overflow  = (w_acc_vld[0] & w_acc_vld[1] & (w_n != 2'd2)) |
                    ((w_acc_vld[0] ^ w_acc_vld[1]) & (w_n == 2'd0));
      w_wp_next   = r_wp + PW'(w_n);
      w_ckpt_dist = w_wp_next - r_ckpt;
      w_illegal   = ckpt_restore & (w_ckpt_dist > PW'(NUM_ENT));
      if (ckpt_restore && !w_illegal) begin
         w_rp_next = r_ckpt;
      end else if (w_alloc) begin
         w_rp_next = r_rp + PW'(1);
      end else begin
         w_rp_next = r_rp;
      end
      w_ckpt_next = (ckpt_take && !ckpt_restore) ? w_rp_next : r_ckpt;
   end

   // Lowest accepted channel lands at WP, the next at WP+1.
   always_comb begin
      w_we0 = (w_n != 2'd0);
      w_we1 = (w_n == 2'd2);
      w_wd0 = w_acc_vld[0] ? w_tag0 : w_tag1;
   end

   // Pointer, checkpoint and sticky-error state; flush keeps the error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rp   <= '0;
         r_wp   <= PW'(NUM_ENT);
         r_ckpt <= '0;
         r_err  <= 1'b0;
      end else if (flush) begin
         r_rp   <= '0;
         r_wp   <= PW'(NUM_ENT);
         r_ckpt <= '0;
      end else begin
         r_rp   <= w_rp_next;
         r_wp   <= w_wp_next;
         r_ckpt <= w_ckpt_next;
         r_err  <= r_err | w_underflow | w_overflow | w_illegal;
      end
   end

   assign w_init = reset | flush;

   tag_fl_storage #(
      .TAG_WIDTH (TAG_WIDTH)
   ) u_storage (
      .clk      (clk),
      .i_init   (w_init),
      .i_we0    (w_we0),
      .i_waddr0 (r_wp[TAG_WIDTH-1:0]),
      .i_wdata0 (w_wd0),
      .i_we1    (w_we1),
      .i_waddr1 (r_wp[TAG_WIDTH-1:0] + TAG_WIDTH'(1)),
      .i_wdata1 (w_tag1),
      .i_raddr  (r_rp[TAG_WIDTH-1:0]),
      .o_rdata  (w_rdata)
   );

   assign tagout_tf = w_bypass ? w_tag0 : w_rdata;
   assign ef_tf     = w_empty;
   assign ff_tf     = (r_wp[TAG_WIDTH-1:0] == r_rp[TAG_WIDTH-1:0]) &
                      (r_wp[TAG_WIDTH] != r_rp[TAG_WIDTH]);
   assign count_tf  = w_count;
   assign err_tf    = r_err;

endmodule

// File: tb/tb_tag_free_list.sv
// Directed self-checking bench for tag_free_list (TAG_WIDTH=6, NUM_RET=2).
// Bypass steps are compiled only when TAG_FL_BYPASS_EN is defined.
module tb_tag_free_list;

   localparam int unsigned TW = 6;
   localparam int unsigned NR = 2;

   logic            clk;
   logic            reset;
   logic            flush;
   logic [NR*TW-1:0] cdb_tag_tf;
   logic [NR-1:0]   cdb_tag_tf_valid;
   logic            ren_tf;
   logic [TW-1:0]   tagout_tf;
   logic            ef_tf;
   logic            ff_tf;
   logic [TW:0]     count_tf;
   logic            ckpt_take;
   logic            ckpt_restore;
   logic            err_tf;

   int n_checks;
   int n_fail;

   tag_free_list #(
      .TAG_WIDTH (TW),
      .NUM_RET   (NR)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .flush            (flush),
      .cdb_tag_tf       (cdb_tag_tf),
      .cdb_tag_tf_valid (cdb_tag_tf_valid),
      .ren_tf           (ren_tf),
      .tagout_tf        (tagout_tf),
      .ef_tf            (ef_tf),
      .ff_tf            (ff_tf),
      .count_tf         (count_tf),
      .ckpt_take        (ckpt_take),
      .ckpt_restore     (ckpt_restore),
      .err_tf           (err_tf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
      end
   endtask

   // Advance one rising edge, then step just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ret(input logic [1:0] v, input logic [TW-1:0] t0, input logic [TW-1:0] t1);
      cdb_tag_tf_valid = v;
      cdb_tag_tf       = {t1, t0};
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; flush = 1'b0; ren_tf = 1'b0;
      ckpt_take = 1'b0; ckpt_restore = 1'b0;
      ret(2'b00, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_ef", 32'(ef_tf), 0);
      check("rst_ff", 32'(ff_tf), 1);
      check("rst_count", 32'(count_tf), 64);
      check("rst_tagout", 32'(tagout_tf), 0);
      check("rst_err", 32'(err_tf), 0);

      // Drain all 64 tags in order.
      ren_tf = 1'b1;
      for (int i = 0; i < 64; i++) begin
         #1;
         check("pop_tag", 32'(tagout_tf), 32'(i));
         tick();
      end
      ren_tf = 1'b0;
      #1;
      check("drain_ef", 32'(ef_tf), 1);
      check("drain_count", 32'(count_tf), 0);
      check("drain_ff", 32'(ff_tf), 0);

      // Two returns in one cycle, then pop them back in channel order.
      ret(2'b11, 5, 9);
      tick();
      ret(2'b00, 0, 0);
      #1;
      check("ret2_count", 32'(count_tf), 2);
      check("ret2_ef", 32'(ef_tf), 0);
      ren_tf = 1'b1;
      #1;
      check("ret2_pop0", 32'(tagout_tf), 5);
      tick();
      check("ret2_pop1", 32'(tagout_tf), 9);
      tick();
      ren_tf = 1'b0;
      #1;
      check("ret2_ef_after", 32'(ef_tf), 1);
      check("ret2_err", 32'(err_tf), 0);

`ifdef TAG_FL_BYPASS_EN
      // Empty list: channel-0 return forwarded straight to the allocation.
      ren_tf = 1'b1;
      ret(2'b01, 17, 0);
      #1;
      check("byp_tagout", 32'(tagout_tf), 17);
      tick();
      ren_tf = 1'b0;
      ret(2'b00, 0, 0);
      #1;
      check("byp_count", 32'(count_tf), 0);
      check("byp_ef", 32'(ef_tf), 1);
      check("byp_err", 32'(err_tf), 0);
`endif

      // Underflow: allocate while empty.
      ren_tf = 1'b1;
      tick();
      ren_tf = 1'b0;
      #1;
      check("uf_err", 32'(err_tf), 1);
      check("uf_count", 32'(count_tf), 0);
      check("uf_ef", 32'(ef_tf), 1);
      // A lone channel-1 return packs to WP; RP must not have moved.
      ret(2'b10, 0, 12);
      tick();
      ret(2'b00, 0, 0);
      #1;
      check("uf_ch1_count", 32'(count_tf), 1);
      check("uf_ch1_tag", 32'(tagout_tf), 12);

      // Flush restores identity contents and a full list but keeps the error.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("flush_count", 32'(count_tf), 64);
      check("flush_tagout", 32'(tagout_tf), 0);
      check("flush_ff", 32'(ff_tf), 1);
      check("flush_err", 32'(err_tf), 1);
      do_reset();
      #1;
      check("reset_err", 32'(err_tf), 0);

      // Return into a full list is dropped.
      ret(2'b01, 3, 0);
      tick();
      ret(2'b00, 0, 0);
      #1;
      check("of_err", 32'(err_tf), 1);
      check("of_count", 32'(count_tf), 64);
      check("of_ff", 32'(ff_tf), 1);
      check("of_tagout", 32'(tagout_tf), 0);

      // Full list: allocation frees the slot the same-cycle return needs.
      do_reset();
      ren_tf = 1'b1;
      ret(2'b01, 33, 0);
      #1;
      check("fullpr_tag", 32'(tagout_tf), 0);
      tick();
      ren_tf = 1'b0;
      ret(2'b00, 0, 0);
      #1;
      check("fullpr_count", 32'(count_tf), 64);
      check("fullpr_err", 32'(err_tf), 0);
      check("fullpr_next", 32'(tagout_tf), 1);

      // One free slot, two returns: channel 0 kept, channel 1 dropped.
      ren_tf = 1'b1;
      tick();
      ren_tf = 1'b0;
      ret(2'b11, 50, 51);
      tick();
      ret(2'b00, 0, 0);
      #1;
      check("part_count", 32'(count_tf), 64);
      check("part_err", 32'(err_tf), 1);

      // Checkpoint after 4 pops, pop 3 more, restore.
      do_reset();
      ren_tf = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("ck_pop", 32'(tagout_tf), 32'(i));
         tick();
      end
      ren_tf = 1'b0;
      ckpt_take = 1'b1;
      tick();
      ckpt_take = 1'b0;
      ren_tf = 1'b1;
      tick(); tick(); tick();
      ren_tf = 1'b0;
      #1;
      check("ck_count_pre", 32'(count_tf), 57);
      ckpt_restore = 1'b1;
      tick();
      ckpt_restore = 1'b0;
      #1;
      check("ck_count", 32'(count_tf), 60);
      check("ck_tagout", 32'(tagout_tf), 4);
      check("ck_err", 32'(err_tf), 0);

      // Illegal restore: RP=7, checkpoint 4, refill to WP=70 (70-4 > 64).
      ren_tf = 1'b1;
      tick(); tick(); tick();
      ren_tf = 1'b0;
      ret(2'b11, 40, 41); tick();
      ret(2'b11, 42, 43); tick();
      ret(2'b11, 44, 45); tick();
      ret(2'b00, 0, 0);
      #1;
      check("ill_count_pre", 32'(count_tf), 63);
      ckpt_restore = 1'b1;
      tick();
      ckpt_restore = 1'b0;
      #1;
      check("ill_err", 32'(err_tf), 1);
      check("ill_count", 32'(count_tf), 63);
      check("ill_tagout", 32'(tagout_tf), 7);

      // Checkpoint taken with an allocation in the same cycle captures RP after it.
      do_reset();
      ren_tf = 1'b1;
      ckpt_take = 1'b1;
      tick();
      ckpt_take = 1'b0;
      tick(); tick();
      ren_tf = 1'b0;
      ckpt_restore = 1'b1;
      tick();
      ckpt_restore = 1'b0;
      #1;
      check("cka_tagout", 32'(tagout_tf), 1);
      check("cka_count", 32'(count_tf), 63);
      check("cka_err", 32'(err_tf), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tag_free_list.md
Name: tag_free_list

Overview:
Parametrised free-tag list for the rename stage. It holds every physical tag not currently allocated and hands one out per `ren` pulse. It accepts up to NUM_RET retired tags per cycle from the CDB/commit path. It adds full/underflow/overflow flags, an occupancy count and single-level checkpoint/restore of the allocation pointer for branch recovery.

Parameters:
TAG_WIDTH, 6, tag width in bits; DEPTH = 2**TAG_WIDTH entries.
NUM_RET, 2, number of tag-return channels per cycle; legal values are 1 or 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous reinitialisation to the reset state; same effect as reset.
cdb_tag_tf  in  NUM_RET*TAG_WIDTH  returned tags; channel k occupies bits [k*TAG_WIDTH +: TAG_WIDTH].
cdb_tag_tf_valid  in  NUM_RET  per-channel return valid.
ren_tf  in  1  allocate request; pops tagout_tf.
tagout_tf  out  TAG_WIDTH  head tag, combinational from storage[RP].
ef_tf  out  1  empty.
ff_tf  out  1  full.
count_tf  out  TAG_WIDTH+1  number of free tags (WP-RP).
ckpt_take  in  1  snapshot RP into the checkpoint register.
ckpt_restore  in  1  RP <= checkpoint register.
err_tf  out  1  sticky error: underflow, overflow or illegal restore.

Behaviour:
- Pointers RP and WP are each TAG_WIDTH+1 bits; the MSB is the wrap bit.
  - ef_tf = (WP==RP).
  - ff_tf = low bits equal and MSBs differ.
  - count_tf = WP-RP, modulo 2**(TAG_WIDTH+1).
- Reset or flush:
  - storage[i] = i for all i.
  - RP = 0; WP = DEPTH (MSB set, list full).
  - Checkpoint register = 0; err_tf = 0.
  - Outputs: ef_tf=0, ff_tf=1, count_tf=DEPTH, tagout_tf=0.
  - reset takes priority over every other input. flush behaves identically but does not clear err_tf.
- Allocation:
  - With ren_tf=1 and ef_tf=0, RP increments by 1 at the edge.
  - tagout_tf is valid in the same cycle as ren_tf (zero latency).
  - ren_tf with ef_tf=1: RP unchanged, err_tf set.
- Return:
  - Valid channels are packed in ascending channel order. The lowest valid channel writes storage[WP], the next writes storage[WP+1].
  - WP advances by the number of accepted returns.
  - Acceptance limit: a return is accepted only if it fits in DEPTH-count_tf+(allocation this cycle ? 1 : 0) free slots. Excess returns are dropped (highest channel first) and set err_tf.
- Simultaneous ren_tf and returns:
  - Both apply. The count is updated by returns minus allocation.
  - A return never bypasses to tagout_tf in the same cycle (see optional feature).
  - Pointer wrap-around is natural modulo arithmetic.
- ckpt_take: the checkpoint register is loaded with the RP value after this cycle's update, i.e. including an allocation made in the same cycle.
- ckpt_restore:
  - RP <= checkpoint register and any ren_tf in the same cycle is ignored.
  - Returns in the same cycle still apply to WP.
  - Illegal restore: if (WP_next - checkpoint) > DEPTH, the restore is ignored and err_tf is set.
  - If ckpt_take and ckpt_restore are both asserted, restore wins and the checkpoint register is unchanged.
- Storage is not cleared on pop; stale contents are don't-care.

Optional Feature:
TAG_FL_BYPASS_EN
- Defined: when ef_tf=1, channel 0 returns a valid tag and ren_tf=1, the tag goes combinationally to tagout_tf and is consumed. It is not written, neither pointer moves and no underflow error is raised. A valid tag on channel 1 in the same cycle is written normally.
- Undefined: no bypass. Underflow is flagged as described under Behaviour.

Decomposition:
- Package tag_fl_pkg holds:
  - default TAG_WIDTH and NUM_RET;
  - localparams DEPTH and PTR_W;
  - a function that computes the accepted-return count from the valid vector and the free space.
- One sub-module, tag_fl_storage: DEPTH x TAG_WIDTH array, two write ports, synchronous reset/flush to identity contents, asynchronous read port.

Test Plan:
1. Reset, then 64 consecutive ren_tf -> tagout_tf = 0..63 in order; ef_tf=1 after the last pop; count_tf=0.
2. Empty list, return tags 5 and 9 on channels 0 and 1 in one cycle -> count_tf=2; next two pops give 5, then 9.
3. Full after reset, return tag 3 on channel 0 -> dropped, err_tf=1, WP unchanged, count_tf=64.
4. Pop 4 tags (0..3), ckpt_take, pop 3 more, ckpt_restore -> count_tf=60; tagout_tf=4.
5. ren_tf with ef_tf=1 -> RP unchanged, err_tf=1. Then flush -> count_tf=64, tagout_tf=0, err_tf stays 1. Then reset -> err_tf=0.
6. Bypass build: empty list, ren_tf together with a channel-0 return of tag 17 -> tagout_tf=17 in that cycle; count_tf stays 0; err_tf=0.
